rtc_bus_responder: RTL and testbench
====================================

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 Parameter TICK_DIV, default 100000000, clk cycles per timekeeping tick (1 Hz at 100 MHz).
REQ-002 clk  in  1  system clock (CLOCK_NEXYS domain).
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 cs  in  1  chip select, active-low, asynchronous to clk.
REQ-005 rd  in  1  read strobe, active-low, asynchronous.
REQ-006 wr  in  1  write strobe, active-low, asynchronous.
REQ-007 ad  in  1  bus phase: 0 = address, 1 = data; asynchronous.
REQ-008 bus_in  in  8  multiplexed address/data from initiator.
REQ-009 bus_out  out  8  read data toward initiator.
REQ-010 bus_oe  out  1  high while responder drives the bus.
REQ-011 bad_addr  out  1  one-cycle pulse on access to an unmapped address or on a protocol error.

Function
REQ-012 cs, rd, wr, ad and bus_in SHALL pass through identical 2-flop synchronizers; edge detection SHALL add one register, giving 3 clk latency from pin to action.
REQ-013 FSM states: IDLE, SEL, RDRIVE, WLOW. IDLE->SEL on cs low. SEL->RDRIVE on rd low with ad=1. SEL->WLOW on wr low. Any state->IDLE on cs high.
REQ-014 In WLOW, a wr rising edge with ad=0 SHALL latch the synchronized bus_in into the address register; with ad=1 it SHALL write the data to the addressed register. Then return to SEL.
REQ-015 In RDRIVE, bus_oe=1 and bus_out = read value of the latched address. Return to SEL on rd high; bus_oe SHALL fall in the same cycle.
REQ-016 rd and wr both low in SEL SHALL execute neither, pulse bad_addr and stay in SEL. rd low with ad=0 SHALL be ignored.
REQ-017 Register map:
- 0x00 status, bit0 = timer expired; a write of any value clears it.
- 0x21..0x26: seconds, minutes, hours, day, month, year, in BCD.
- 0x41..0x43: timer seconds, minutes, hours, in BCD.
REQ-018 An address-phase write of 0xF0 SHALL snapshot 0x21..0x26 into a read shadow. Reads of 0x21..0x26 SHALL return the shadow; writes SHALL go to the live registers.
REQ-019 Reads of 0x41..0x43 and 0x00 SHALL return the live values.
REQ-020 Reads or writes of unmapped addresses SHALL read 0x00, write nothing, and pulse bad_addr once per strobe.
REQ-021 cs high mid-transaction SHALL abort it: no write, bus_oe=0 next cycle.

Reset
REQ-022 On rst: state IDLE, bus_out=0x00, bus_oe=0, bad_addr=0, address register 0x00, synchronizers at idle level (high).
REQ-023 On rst: time 00:00:00, day 0x01, month 0x01, year 0x00, shadow equal to live, timer 000000, status 0x00, prescaler 0.

Configuration
REQ-024 Macro RTC_RESP_TICK_EN.
- Defined: a prescaler tick each TICK_DIV cycles.
  - Each tick SHALL increment the BCD seconds. 59->00 carries into minutes, minutes 59->00 carries into hours, hours 23->00. There is no date carry.
  - A nonzero timer SHALL count down once per tick, with BCD borrow. On reaching 000000 it SHALL set status bit0.
  - A write to 0x21 SHALL clear the prescaler.
  - A bus write and a tick on the same cycle: the bus write wins for the written register.
- Undefined: all registers are plain storage, no prescaler logic, status bit0 stays 0.

Structure
REQ-025 Package rtc_resp_pkg SHALL hold the FSM state typedef and the address constants (ADDR_STATUS, ADDR_SEG..ADDR_ANIO, ADDR_TSEG..ADDR_THORA, ADDR_CMD_XFER = 0xF0).
REQ-026 Sub-module rtc_strobe_sync (2-flop synchronizer plus edge detect) SHALL be instantiated for the control strobes.

Verification
REQ-027 Address-phase write 0x22, then data write 0x45, then 0xF0, then read 0x22 -> bus_out=0x45, bus_oe high 3 clk after rd falls.
REQ-028 Read of 0x30 -> bus_out=0x00, one bad_addr pulse, no register changes.
REQ-029 With RTC_RESP_TICK_EN and TICK_DIV=4, write 0x23=0x23, 0x22=0x59, 0x21=0x59; wait one tick; 0xF0; read -> 00:00:00.
REQ-030 With RTC_RESP_TICK_EN, set timer 000002; after 2 ticks -> status=0x01; write 0x00 -> status=0x00.
REQ-031 Pull cs high during a read -> bus_oe=0 within 4 clk; the next write still succeeds.
REQ-032 Assert rst mid-write -> all registers at reset values, bus_oe=0.

Source files
------------

// File: rtl/rtc_resp_pkg.sv
// Shared types, register map and BCD helpers for the RTC bus responder.
package rtc_resp_pkg;

   // Bus-side transaction state
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEL    = 2'd1,
      ST_RDRIVE = 2'd2,
      ST_WLOW   = 2'd3
   } state_t;

   // Register map
   localparam logic [7:0] ADDR_STATUS   = 8'h00;
   localparam logic [7:0] ADDR_SEG      = 8'h21;
   localparam logic [7:0] ADDR_MIN      = 8'h22;
   localparam logic [7:0] ADDR_HORA     = 8'h23;
   localparam logic [7:0] ADDR_DIA      = 8'h24;
   localparam logic [7:0] ADDR_MES      = 8'h25;
   localparam logic [7:0] ADDR_ANIO     = 8'h26;
   localparam logic [7:0] ADDR_TSEG     = 8'h41;
   localparam logic [7:0] ADDR_TMIN     = 8'h42;
   localparam logic [7:0] ADDR_THORA    = 8'h43;
   localparam logic [7:0] ADDR_CMD_XFER = 8'hF0;

   // Bit positions of the control strobes inside the synchronizer vector
   localparam int unsigned STB_CS = 0;
   localparam int unsigned STB_RD = 1;
   localparam int unsigned STB_WR = 2;
   localparam int unsigned STB_AD = 3;

   function automatic logic addr_mapped(input logic [7:0] a);
      case (a)
         ADDR_STATUS, ADDR_SEG, ADDR_MIN, ADDR_HORA, ADDR_DIA, ADDR_MES,
         ADDR_ANIO, ADDR_TSEG, ADDR_TMIN, ADDR_THORA: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Two-digit BCD increment without wrap handling (caller handles limits)
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // Two-digit BCD decrement; caller never passes 0x00
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                return {v[7:4], v[3:0] - 4'd1};
   endfunction

endpackage

// File: rtl/rtc_strobe_sync.sv
// Two-flop synchronizer with one history stage for edge detection.
// All stages reset to the idle (high) level of the active-low bus pins.
module rtc_strobe_sync #(
   parameter int unsigned W = 1
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [W-1:0] i_async,
   output logic [W-1:0] o_level,
   output logic [W-1:0] o_rise,
   output logic [W-1:0] o_fall
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_sync;
   logic [W-1:0] r_prev;

   // Capture the pins, settle them, and keep one cycle of history
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= '1;
         r_sync <= '1;
         r_prev <= '1;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_level = r_sync;
   assign o_rise  = r_sync & ~r_prev;
   assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/rtc_bus_responder.sv
// RTC register file behind an asynchronous multiplexed address/data bus.
// Optional timekeeping (seconds/minutes/hours and countdown timer) is built
// only when RTC_RESP_TICK_EN is defined; otherwise registers are plain storage.
module rtc_bus_responder #(
   parameter int unsigned TICK_DIV = 100000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       rd,
   input  logic       wr,
   input  logic       ad,
   input  logic [7:0] bus_in,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic       bad_addr
);
   import rtc_resp_pkg::*;

   logic [3:0] w_stb_lvl, w_stb_rise, w_stb_fall;
   logic [7:0] w_bus, w_bus_rise, w_bus_fall;
   logic       w_cs, w_rd, w_wr, w_ad, w_rd_fall, w_wr_fall, w_wr_rise;
   logic       w_unused;

   state_t     r_state, w_state_nx;
   logic       w_do_addr, w_do_wdata, w_do_snap, w_bad_nx;
   logic       r_bad;
   logic [7:0] r_addr;
   logic [7:0] w_rd_val;

   logic [7:0] r_sec, r_min, r_hora, r_dia, r_mes, r_anio;
   logic [7:0] r_shd_sec, r_shd_min, r_shd_hora, r_shd_dia, r_shd_mes, r_shd_anio;
   logic [7:0] r_tseg, r_tmin, r_thora;
   logic       r_tmr_exp;
   logic [7:0] w_sec_nx, w_min_nx, w_hora_nx, w_dia_nx, w_mes_nx, w_anio_nx;
   logic [7:0] w_tseg_nx, w_tmin_nx, w_thora_nx;
   logic       w_tmr_exp_nx;

   rtc_strobe_sync #(.W(4)) u_strobe_sync (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async ({ad, wr, rd, cs}),
      .o_level (w_stb_lvl),
      .o_rise  (w_stb_rise),
      .o_fall  (w_stb_fall)
   );

   rtc_strobe_sync #(.W(8)) u_bus_sync (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_async (bus_in),
      .o_level (w_bus),
      .o_rise  (w_bus_rise),
      .o_fall  (w_bus_fall)
   );

   assign w_cs      = w_stb_lvl[STB_CS];
   assign w_rd      = w_stb_lvl[STB_RD];
   assign w_wr      = w_stb_lvl[STB_WR];
   assign w_ad      = w_stb_lvl[STB_AD];
   assign w_rd_fall = w_stb_fall[STB_RD];
   assign w_wr_fall = w_stb_fall[STB_WR];
   assign w_wr_rise = w_stb_rise[STB_WR];
   assign w_unused  = ^{w_stb_rise, w_stb_fall, w_bus_rise, w_bus_fall};

`ifdef RTC_RESP_TICK_EN
   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   logic [PW-1:0] r_presc;
   logic          w_tick;
   logic          w_seg_wr;

   assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
   assign w_seg_wr = w_do_wdata && (r_addr == ADDR_SEG);

   // Prescaler; a seconds write restarts the current second
   always_ff @(posedge clk) begin
      if (rst)                   r_presc <= '0;
      else if (w_tick || w_seg_wr) r_presc <= '0;
      else                       r_presc <= r_presc + 1'b1;
   end
`else
   localparam int unsigned tick_div_unused = TICK_DIV;
`endif

   // Next state and bus actions; cs high aborts from any state
   always_comb begin
      w_state_nx = r_state;
      w_do_addr  = 1'b0;
      w_do_wdata = 1'b0;
      w_bad_nx   = 1'b0;
      if (w_cs) begin
         w_state_nx = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: w_state_nx = ST_SEL;
            ST_SEL: begin
               if (!w_rd && !w_wr) begin
                  w_bad_nx = w_rd_fall || w_wr_fall;
               end else if (!w_rd && w_ad) begin
                  w_state_nx = ST_RDRIVE;
                  w_bad_nx   = !addr_mapped(r_addr);
               end else if (!w_wr) begin
                  w_state_nx = ST_WLOW;
               end
            end
            ST_RDRIVE: if (w_rd) w_state_nx = ST_SEL;
            ST_WLOW: begin
               if (w_wr_rise) begin
                  w_state_nx = ST_SEL;
                  if (w_ad) begin
                     w_do_wdata = addr_mapped(r_addr);
                     w_bad_nx   = !addr_mapped(r_addr);
                  end else begin
                     w_do_addr = 1'b1;
                  end
               end
            end
            default: w_state_nx = ST_IDLE;
         endcase
      end
   end

   assign w_do_snap = w_do_addr && (w_bus == ADDR_CMD_XFER);

   // State, address latch and registered error pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_addr  <= '0;
         r_bad   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_bad   <= w_bad_nx;
         if (w_do_addr) r_addr <= w_bus;
      end
   end

   // Register next values: tick update first, then the bus write overrides
   // only the register it targets
   always_comb begin
      w_sec_nx     = r_sec;
      w_min_nx     = r_min;
      w_hora_nx    = r_hora;
      w_dia_nx     = r_dia;
      w_mes_nx     = r_mes;
      w_anio_nx    = r_anio;
      w_tseg_nx    = r_tseg;
      w_tmin_nx    = r_tmin;
      w_thora_nx   = r_thora;
      w_tmr_exp_nx = r_tmr_exp;
`ifdef RTC_RESP_TICK_EN
      if (w_tick) begin
         if (r_sec == 8'h59) begin
            w_sec_nx = 8'h00;
            if (r_min == 8'h59) begin
               w_min_nx  = 8'h00;
               w_hora_nx = (r_hora == 8'h23) ? 8'h00 : bcd_inc(r_hora);
            end else begin
               w_min_nx = bcd_inc(r_min);
            end
         end else begin
            w_sec_nx = bcd_inc(r_sec);
         end
         if ((r_tseg | r_tmin | r_thora) != 8'h00) begin
            if (r_tseg != 8'h00) begin
               w_tseg_nx = bcd_dec(r_tseg);
            end else begin
               w_tseg_nx = 8'h59;
               if (r_tmin != 8'h00) begin
                  w_tmin_nx = bcd_dec(r_tmin);
               end else begin
                  w_tmin_nx  = 8'h59;
                  w_thora_nx = bcd_dec(r_thora);
               end
            end
            if ((w_tseg_nx | w_tmin_nx | w_thora_nx) == 8'h00) w_tmr_exp_nx = 1'b1;
         end
      end
`endif
      if (w_do_wdata) begin
         case (r_addr)
            ADDR_STATUS: w_tmr_exp_nx = 1'b0;
            ADDR_SEG:    w_sec_nx     = w_bus;
            ADDR_MIN:    w_min_nx     = w_bus;
            ADDR_HORA:   w_hora_nx    = w_bus;
            ADDR_DIA:    w_dia_nx     = w_bus;
            ADDR_MES:    w_mes_nx     = w_bus;
            ADDR_ANIO:   w_anio_nx    = w_bus;
            ADDR_TSEG:   w_tseg_nx    = w_bus;
            ADDR_TMIN:   w_tmin_nx    = w_bus;
            ADDR_THORA:  w_thora_nx   = w_bus;
            default: ;
         endcase
      end
   end

   // Live registers and the read shadow of the calendar/time block
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sec      <= 8'h00;
         r_min      <= 8'h00;
         r_hora     <= 8'h00;
         r_dia      <= 8'h01;
         r_mes      <= 8'h01;
         r_anio     <= 8'h00;
         r_shd_sec  <= 8'h00;
         r_shd_min  <= 8'h00;
         r_shd_hora <= 8'h00;
         r_shd_dia  <= 8'h01;
         r_shd_mes  <= 8'h01;
         r_shd_anio <= 8'h00;
         r_tseg     <= 8'h00;
         r_tmin     <= 8'h00;
         r_thora    <= 8'h00;
         r_tmr_exp  <= 1'b0;
      end else begin
         r_sec     <= w_sec_nx;
         r_min     <= w_min_nx;
         r_hora    <= w_hora_nx;
         r_dia     <= w_dia_nx;
         r_mes     <= w_mes_nx;
         r_anio    <= w_anio_nx;
         r_tseg    <= w_tseg_nx;
         r_tmin    <= w_tmin_nx;
         r_thora   <= w_thora_nx;
         r_tmr_exp <= w_tmr_exp_nx;
         if (w_do_snap) begin
            r_shd_sec  <= r_sec;
            r_shd_min  <= r_min;
            r_shd_hora <= r_hora;
            r_shd_dia  <= r_dia;
            r_shd_mes  <= r_mes;
            r_shd_anio <= r_anio;
         end
      end
   end

   // Read mux: time block from the shadow, timer and status live
   always_comb begin
      case (r_addr)
         ADDR_STATUS: w_rd_val = {7'd0, r_tmr_exp};
         ADDR_SEG:    w_rd_val = r_shd_sec;
         ADDR_MIN:    w_rd_val = r_shd_min;
         ADDR_HORA:   w_rd_val = r_shd_hora;
         ADDR_DIA:    w_rd_val = r_shd_dia;
         ADDR_MES:    w_rd_val = r_shd_mes;
         ADDR_ANIO:   w_rd_val = r_shd_anio;
         ADDR_TSEG:   w_rd_val = r_tseg;
         ADDR_TMIN:   w_rd_val = r_tmin;
         ADDR_THORA:  w_rd_val = r_thora;
         default:     w_rd_val = '0;
      endcase
   end

   assign bus_oe   = (r_state == ST_RDRIVE);
   assign bus_out  = bus_oe ? w_rd_val : '0;
   assign bad_addr = r_bad;

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Directed bench for rtc_bus_responder; tick tests build with RTC_RESP_TICK_EN.
module tb_rtc_bus_responder;

`ifdef RTC_RESP_TICK_EN
   localparam int unsigned TB_DIV = 4;
`else
   localparam int unsigned TB_DIV = 100;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cs = 1'b1, rd = 1'b1, wr = 1'b1, ad = 1'b0;
   logic [7:0] bus_in = 8'h00;
   logic [7:0] bus_out;
   logic       bus_oe, bad_addr;
   int         checks = 0;
   int         errors = 0;
   int         bad_cnt = 0;

   always #5 clk = ~clk;

   rtc_bus_responder #(.TICK_DIV(TB_DIV)) dut (
      .clk      (clk),
      .rst      (rst),
      .cs       (cs),
      .rd       (rd),
      .wr       (wr),
      .ad       (ad),
      .bus_in   (bus_in),
      .bus_out  (bus_out),
      .bus_oe   (bus_oe),
      .bad_addr (bad_addr)
   );

   always @(negedge clk) if (bad_addr === 1'b1) bad_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cs_on();
      cs = 1'b0;
      step(4);
   endtask

   task automatic bus_wr(input logic a, input logic [7:0] v);
      ad = a;
      bus_in = v;
      step(2);
      wr = 1'b0;
      step(5);
      wr = 1'b1;
      step(5);
   endtask

   task automatic bus_rd(output logic [7:0] d, output int lat, output int rel);
      ad = 1'b1;
      step(2);
      rd = 1'b0;
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         if (bus_oe === 1'b1) begin lat = i; break; end
      end
      d = bus_out;
      rd = 1'b1;
      rel = -1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         if (bus_oe === 1'b0) begin rel = i; break; end
      end
      step(3);
   endtask

   task automatic rreg(input logic [7:0] a, output logic [7:0] d);
      int lat, rel;
      bus_wr(1'b0, a);
      bus_rd(d, lat, rel);
   endtask

   task automatic wreg(input logic [7:0] a, input logic [7:0] v);
      bus_wr(1'b0, a);
      bus_wr(1'b1, v);
   endtask

   task automatic test_reset();
      logic [7:0] d;
      int lat, rel;
      rst = 1'b1; cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b0; bus_in = 8'h00;
      step(3);
      checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", bus_oe); end
      checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h expected 00", bus_out); end
      checks++; if (bad_addr !== 1'b0) begin errors++; $display("FAIL reset_bad: got %b expected 0", bad_addr); end
      rst = 1'b0;
      step(2);
      cs_on();
      bus_rd(d, lat, rel);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_status: got %h expected 00", d); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL reset_rd_latency: got %0d expected 3", lat); end
      rreg(8'h24, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL reset_day: got %h expected 01", d); end
      rreg(8'h25, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL reset_month: got %h expected 01", d); end
      rreg(8'h26, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_year: got %h expected 00", d); end
`ifndef RTC_RESP_TICK_EN
      rreg(8'h23, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_hours: got %h expected 00", d); end
      rreg(8'h41, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_tseg: got %h expected 00", d); end
`endif
   endtask

   task automatic test_shadow_read();
      logic [7:0] d;
      int lat, rel, b0;
      b0 = bad_cnt;
      wreg(8'h21, 8'h00);
      wreg(8'h22, 8'h45);
      bus_wr(1'b0, 8'hF0);
      bus_wr(1'b0, 8'h22);
      bus_rd(d, lat, rel);
      checks++; if (d !== 8'h45) begin errors++; $display("FAIL shadow_min: got %h expected 45", d); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL oe_rise_latency: got %0d expected 3", lat); end
      checks++; if (rel !== 3) begin errors++; $display("FAIL oe_fall_latency: got %0d expected 3", rel); end
      checks++; if (bad_cnt !== b0) begin errors++; $display("FAIL mapped_no_bad: got %0d pulses expected 0", bad_cnt - b0); end
   endtask

   task automatic test_shadow_isolation();
      logic [7:0] d;
      wreg(8'h24, 8'h31);
      rreg(8'h24, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL shadow_stale: got %h expected 01", d); end
      bus_wr(1'b0, 8'hF0);
      rreg(8'h24, d);
      checks++; if (d !== 8'h31) begin errors++; $display("FAIL shadow_updated: got %h expected 31", d); end
   endtask

   task automatic test_unmapped();
      logic [7:0] d;
      int lat, rel, b0;
      b0 = bad_cnt;
      bus_wr(1'b0, 8'h30);
      bus_rd(d, lat, rel);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_rd_data: got %h expected 00", d); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL unmapped_rd_oe: got %0d expected 3", lat); end
      checks++; if (bad_cnt - b0 !== 1) begin errors++; $display("FAIL unmapped_rd_bad: got %0d pulses expected 1", bad_cnt - b0); end
      wreg(8'h50, 8'hAA);
      checks++; if (bad_cnt - b0 !== 2) begin errors++; $display("FAIL unmapped_wr_bad: got %0d pulses expected 2", bad_cnt - b0); end
      bus_wr(1'b0, 8'hF0);
      rreg(8'h24, d);
      checks++; if (d !== 8'h31) begin errors++; $display("FAIL unmapped_no_change_day: got %h expected 31", d); end
      rreg(8'h00, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped_no_change_status: got %h expected 00", d); end
      checks++; if (bad_cnt - b0 !== 2) begin errors++; $display("FAIL unmapped_bad_total: got %0d pulses expected 2", bad_cnt - b0); end
   endtask

   task automatic test_protocol_error();
      logic [7:0] d;
      int b0, oe_seen;
      bus_wr(1'b0, 8'h25);
      ad = 1'b1;
      bus_in = 8'h12;
      step(2);
      b0 = bad_cnt;
      oe_seen = 0;
      rd = 1'b0;
      wr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (bus_oe !== 1'b0) oe_seen++;
      end
      rd = 1'b1;
      wr = 1'b1;
      step(6);
      checks++; if (oe_seen !== 0) begin errors++; $display("FAIL proto_no_drive: got %0d oe cycles expected 0", oe_seen); end
      checks++; if (bad_cnt - b0 !== 1) begin errors++; $display("FAIL proto_bad: got %0d pulses expected 1", bad_cnt - b0); end
      bus_wr(1'b0, 8'hF0);
      rreg(8'h25, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL proto_no_write: got %h expected 01", d); end
      ad = 1'b0;
      step(2);
      oe_seen = 0;
      rd = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (bus_oe !== 1'b0) oe_seen++;
      end
      rd = 1'b1;
      step(5);
      checks++; if (oe_seen !== 0) begin errors++; $display("FAIL rd_addr_phase_ignored: got %0d oe cycles expected 0", oe_seen); end
   endtask

   task automatic test_cs_abort();
      logic [7:0] d;
      int lat, drop;
      bus_wr(1'b0, 8'h24);
      ad = 1'b1;
      step(2);
      rd = 1'b0;
      lat = -1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         if (bus_oe === 1'b1) begin lat = i; break; end
      end
      checks++; if (lat !== 3) begin errors++; $display("FAIL abort_rd_start: got %0d expected 3", lat); end
      cs = 1'b1;
      drop = -1;
      for (int i = 1; i <= 8; i++) begin
         step(1);
         if (bus_oe === 1'b0) begin drop = i; break; end
      end
      checks++; if (drop < 1 || drop > 4) begin errors++; $display("FAIL abort_oe_drop: got %0d cycles required 1..4", drop); end
      rd = 1'b1;
      step(3);
      cs_on();
      bus_wr(1'b0, 8'h26);
      ad = 1'b1;
      bus_in = 8'h99;
      step(2);
      wr = 1'b0;
      step(5);
      cs = 1'b1;
      step(1);
      wr = 1'b1;
      step(5);
      cs_on();
      wreg(8'h24, 8'h15);
      bus_wr(1'b0, 8'hF0);
      rreg(8'h24, d);
      checks++; if (d !== 8'h15) begin errors++; $display("FAIL abort_next_write: got %h expected 15", d); end
      rreg(8'h26, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_no_write: got %h expected 00", d); end
   endtask

   task automatic test_reset_mid_write();
      logic [7:0] d;
      int lat, rel;
      bus_wr(1'b0, 8'h25);
      ad = 1'b1;
      bus_in = 8'h11;
      step(2);
      wr = 1'b0;
      step(3);
      rst = 1'b1;
      step(2);
      checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b expected 0", bus_oe); end
      checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL rst_mid_out: got %h expected 00", bus_out); end
      cs = 1'b1; wr = 1'b1; rd = 1'b1; ad = 1'b0;
      step(2);
      rst = 1'b0;
      step(2);
      cs_on();
      bus_rd(d, lat, rel);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_addr_status: got %h expected 00", d); end
      rreg(8'h24, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL rst_mid_shadow_day: got %h expected 01", d); end
      bus_wr(1'b0, 8'hF0);
      rreg(8'h24, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL rst_mid_live_day: got %h expected 01", d); end
      rreg(8'h25, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL rst_mid_month: got %h expected 01", d); end
   endtask

`ifdef RTC_RESP_TICK_EN
   task automatic test_tick_rollover();
      logic [7:0] d;
      wreg(8'h21, 8'h00);
      wreg(8'h23, 8'h23);
      wreg(8'h22, 8'h59);
      bus_wr(1'b0, 8'h21);
      // seconds data write, then an immediately following 0xF0 address write
      // whose action lands between the first and second tick after it
      ad = 1'b1;
      bus_in = 8'h59;
      step(2);
      wr = 1'b0;
      step(5);
      wr = 1'b1;
      step(1);
      ad = 1'b0;
      bus_in = 8'hF0;
      wr = 1'b0;
      step(4);
      wr = 1'b1;
      step(5);
      rreg(8'h21, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL tick_sec_wrap: got %h expected 00", d); end
      rreg(8'h22, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL tick_min_wrap: got %h expected 00", d); end
      rreg(8'h23, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL tick_hour_wrap: got %h expected 00", d); end
   endtask

   task automatic test_timer();
      logic [7:0] d;
      int lat, rel;
      wreg(8'h43, 8'h00);
      wreg(8'h42, 8'h00);
      wreg(8'h41, 8'h02);
      step(10);
      rreg(8'h00, d);
      checks++; if (d !== 8'h01) begin errors++; $display("FAIL timer_expired: got %h expected 01", d); end
      rreg(8'h41, d);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL timer_zero: got %h expected 00", d); end
      wreg(8'h00, 8'h5A);
      bus_rd(d, lat, rel);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL status_clear: got %h expected 00", d); end
   endtask
`endif

   initial begin
      test_reset();
      test_shadow_read();
      test_shadow_isolation();
      test_unmapped();
      test_protocol_error();
      test_cs_abort();
      test_reset_mid_write();
`ifdef RTC_RESP_TICK_EN
      test_tick_rollover();
      test_timer();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
